psum_collector: RTL and testbench
=================================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter col, default 8, number of systolic columns collected.
REQ-002 SHALL have parameter psum_bw, default 16, partial-sum width per column.
REQ-003 SHALL have parameter depth, default 16, per-column lane depth (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port in  input  psum_bw*col  south psums, column i at bits [i*psum_bw +: psum_bw].
REQ-007 SHALL have port wr  input  col  per-column write strobe, driven by the row valid bits.
REQ-008 SHALL have port rd  input  1  pop request for one aligned row.
REQ-009 SHALL have port out  output  psum_bw*col  head entry of every lane, same column packing as in.
REQ-010 SHALL have port o_valid  output  1  high when every lane is non-empty.
REQ-011 SHALL have port o_full  output  1  high when any lane holds depth entries.
REQ-012 SHALL have port o_overflow  output  1  sticky flag for a dropped write.

Function
REQ-013 SHALL implement col independent circular lanes, each with write pointer, read pointer (log2(depth) bits, wrapping depth-1 -> 0) and occupancy count (0..depth).
REQ-014 SHALL write lane i on a rising edge when wr[i]=1 and the lane is accepting; the slot at the write pointer takes in[i], and the pointer and count increment.
REQ-015 SHALL treat a lane as accepting when count<depth, or when count=depth and a pop occurs in the same cycle.
REQ-016 SHALL drop the write when wr[i]=1 and lane i is not accepting, leave that lane unchanged, and set o_overflow=1 on the next edge.
REQ-017 SHALL hold o_overflow at 1 until reset.
REQ-018 SHALL pop when rd=1 and o_valid=1; a pop advances every lane read pointer by one and decrements every count.
REQ-019 SHALL ignore rd when o_valid=0, with no state change and no error flag.
REQ-020 SHALL, on a simultaneous write and pop on one lane, perform both and leave that lane's count unchanged.
REQ-021 SHALL drive out combinationally from each lane's read-pointer slot (first-word fall-through).
REQ-022 SHALL make a word written at edge N visible on out, and counted in o_valid, from edge N onward; write-to-o_valid latency is one cycle.
REQ-023 SHALL derive o_valid = AND over lanes of (count!=0) and o_full = OR over lanes of (count==depth), both from registered counts.
REQ-024 SHALL accept skewed writes; columns written in different cycles align by lane position only.
REQ-025 SHALL store psums unmodified, with no sign or width conversion.

Reset
REQ-026 SHALL, while reset=0, asynchronously clear all pointers, counts, storage and o_overflow to 0.
REQ-027 SHALL drive out=0, o_valid=0, o_full=0 and o_overflow=0 while reset=0 and immediately after release.
REQ-028 SHALL discard all contents on reset asserted mid-operation, with no partial pop or write completing.
REQ-029 SHALL honour wr and rd from the first rising edge after reset returns to 1.

Verification
REQ-030 SHALL pass a skewed-fill test: wr[i] pulsed at cycle i with in lane i = 0x0100+i, col=8 -> o_valid rises one cycle after the lane-7 write, and out lane i = 0x0100+i.
REQ-031 SHALL pass an order test: 3 full rows written, then rd held for 3 cycles -> rows read in write order, o_valid=0 after the third pop.
REQ-032 SHALL pass a full/overflow test: 16 writes to all lanes, then a 17th write without rd -> o_full=1, o_overflow=1, 17th data absent, head still equals the first row.
REQ-033 SHALL pass a full-plus-pop test: all lanes full, then wr=all-ones with rd=1 in one cycle -> the write is accepted, counts stay 16, o_overflow stays 0.
REQ-034 SHALL pass a wrap test: 40 write/pop pairs with an incrementing pattern -> no loss or reordering across pointer wrap.
REQ-035 SHALL pass a reset test: reset=0 asserted mid-stream between edges -> all outputs 0 immediately, then the first post-release row is read correctly.

Source files
------------

// File: rtl/psum_collector.sv
// psum_collector: per-column circular lanes that realign skewed systolic
// partial sums into complete rows. A row pops only when every lane has data.
module psum_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_overflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);
  localparam logic [cw-1:0] depth_c = cw'(depth);

  logic [psum_bw-1:0] mem    [col][depth];
  logic [aw-1:0]      wr_ptr [col];
  logic [aw-1:0]      rd_ptr [col];
  logic [cw-1:0]      count  [col];

  logic [col-1:0] nonempty;
  logic [col-1:0] full;
  logic [col-1:0] accept;
  logic [col-1:0] drop;
  logic           pop;

  // Occupancy flags, pop qualification and per-lane write acceptance.
  // A full lane still accepts when the same edge pops a row out of it.
  always_comb begin
    nonempty = '0;
    full     = '0;
    accept   = '0;
    for (int i = 0; i < col; i++) begin
      nonempty[i] = (count[i] != '0);
      full[i]     = (count[i] == depth_c);
    end
    pop = rd & (&nonempty);
    for (int i = 0; i < col; i++) begin
      accept[i] = wr[i] & (~full[i] | pop);
    end
    drop = wr & ~accept;
  end

  assign o_valid = &nonempty;
  assign o_full  = |full;

  // Lane storage, pointers and counts; storage is cleared on reset so the
  // fall-through output reads zero while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        for (int j = 0; j < depth; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < col; i++) begin
        if (accept[i]) begin
          mem[i][wr_ptr[i]] <= in[i*psum_bw +: psum_bw];
          wr_ptr[i]         <= wr_ptr[i] + aw'(1);
        end
        if (pop) begin
          rd_ptr[i] <= rd_ptr[i] + aw'(1);
        end
        case ({accept[i], pop})
          2'b10:   count[i] <= count[i] + cw'(1);
          2'b01:   count[i] <= count[i] - cw'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Sticky record of any write that found its lane full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_overflow <= 1'b0;
    end else if (|drop) begin
      o_overflow <= 1'b1;
    end
  end

  // First-word fall-through: each lane's head slot drives its column.
  for (genvar g = 0; g < col; g++) begin : g_out
    assign out[g*psum_bw +: psum_bw] = mem[g][rd_ptr[g]];
  end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector with default parameters (8 x 16b x 16).
module tb_psum_collector;

  localparam int W = 128;

  logic         clk;
  logic         reset;
  logic [W-1:0] in;
  logic [7:0]   wr;
  logic         rd;
  logic [W-1:0] out;
  logic         o_valid;
  logic         o_full;
  logic         o_overflow;

  int tests_run = 0;
  int tests_failed = 0;

  psum_collector dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .wr         (wr),
    .rd         (rd),
    .out        (out),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row whose lane i holds base + i.
  function automatic logic [W-1:0] mkrow(input logic [15:0] base);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = base + 16'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] skew;

  initial begin
    reset = 1'b0;
    in    = '0;
    wr    = '0;
    rd    = 1'b0;

    // reset state
    #2;
    check("rst_out", out, '0);
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_full", W'(o_full), W'(0));
    check("rst_ovf", W'(o_overflow), W'(0));
    #10 reset = 1'b1;   // released at t=12, first edge at t=15
    tick();

    // skewed fill: lane i written in cycle i
    skew = '0;
    for (int i = 0; i < 8; i++) begin
      in = {8{16'hDEAD}};
      in[i*16 +: 16] = 16'h0100 + 16'(i);
      skew[i*16 +: 16] = 16'h0100 + 16'(i);
      wr = 8'(1 << i);
      tick();
      if (i < 7) check($sformatf("skew_valid_%0d", i), W'(o_valid), W'(0));
    end
    wr = '0;
    check("skew_valid_rise", W'(o_valid), W'(1));
    check("skew_out", out, skew);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("skew_drained", W'(o_valid), W'(0));

    // rd while empty is ignored
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("empty_rd_valid", W'(o_valid), W'(0));
    check("empty_rd_ovf", W'(o_overflow), W'(0));

    // order: three rows then three pops
    wr = 8'hFF;
    for (int r = 0; r < 3; r++) begin
      in = mkrow(16'h1000 * 16'(r + 1));
      tick();
    end
    wr = '0;
    rd = 1'b1;
    for (int r = 0; r < 3; r++) begin
      check($sformatf("order_row%0d", r), out, mkrow(16'h1000 * 16'(r + 1)));
      tick();
    end
    rd = 1'b0;
    check("order_empty", W'(o_valid), W'(0));

    // full then dropped 17th write
    wr = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      in = mkrow(16'h2000 + 16'(k * 16));
      tick();
      if (k == 14) check("fill_not_full", W'(o_full), W'(0));
    end
    check("fill_full", W'(o_full), W'(1));
    check("fill_no_ovf", W'(o_overflow), W'(0));
    in = {8{16'hEEEE}};
    tick();
    wr = '0;
    check("ovf_set", W'(o_overflow), W'(1));
    check("ovf_full", W'(o_full), W'(1));
    check("ovf_head", out, mkrow(16'h2000));
    rd = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ovf_drain%0d", k), out, mkrow(16'h2000 + 16'(k * 16)));
      tick();
    end
    rd = 1'b0;
    check("ovf_drained", W'(o_valid), W'(0));
    check("ovf_sticky", W'(o_overflow), W'(1));

    // reset mid-stream, asserted and released between edges
    wr = 8'hFF;
    in = mkrow(16'h4000);
    tick();
    in = mkrow(16'h4100);
    tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out", out, '0);
    check("mid_rst_valid", W'(o_valid), W'(0));
    check("mid_rst_ovf", W'(o_overflow), W'(0));
    rd = 1'b1;
    tick();
    check("mid_rst_hold", out, '0);
    #3 reset = 1'b1;
    rd = 1'b0;
    in = mkrow(16'h4200);
    tick();
    wr = '0;
    check("post_rst_out", out, mkrow(16'h4200));
    check("post_rst_valid", W'(o_valid), W'(1));
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("post_rst_empty", W'(o_valid), W'(0));

    // full plus simultaneous pop: write accepted
    wr = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      in = mkrow(16'h3000 + 16'(k * 16));
      tick();
    end
    in = mkrow(16'h3F00);
    rd = 1'b1;
    tick();
    wr = '0;
    check("fpp_full", W'(o_full), W'(1));
    check("fpp_no_ovf", W'(o_overflow), W'(0));
    for (int k = 1; k < 16; k++) begin
      check($sformatf("fpp_drain%0d", k), out, mkrow(16'h3000 + 16'(k * 16)));
      tick();
    end
    check("fpp_new_row", out, mkrow(16'h3F00));
    tick();
    rd = 1'b0;
    check("fpp_empty", W'(o_valid), W'(0));

    // wrap: streaming write/pop across several pointer wraps
    wr = 8'hFF;
    in = mkrow(16'h5000);
    tick();
    rd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      in = mkrow(16'h5000 + 16'((k + 1) * 16));
      check($sformatf("wrap%0d", k), out, mkrow(16'h5000 + 16'(k * 16)));
      tick();
    end
    wr = '0;
    check("wrap_last", out, mkrow(16'h5000 + 16'(40 * 16)));
    check("wrap_not_full", W'(o_full), W'(0));
    tick();
    rd = 1'b0;
    check("wrap_empty", W'(o_valid), W'(0));
    check("wrap_no_ovf", W'(o_overflow), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
